// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types and widths for the ALU issue/writeback sequencer.
//   DW  : operand width
//   RW  : register index width
//   OPW : ALU opcode width
//   state_t : sequencer states IDLE -> ISSUE -> CAPTURE -> WB
//   instr_t : one instruction as offered on the issue port
package alu_pkg;

  localparam int DW  = 8;
  localparam int RW  = 3;
  localparam int OPW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    WB      = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  ra;
    logic [RW-1:0]  rb;
    logic           imm_en;
    logic [DW-1:0]  imm;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREGS x DW register file for the issue sequencer.
//   Two combinational operand read ports, one combinational debug read
//   port and one synchronous write port. Reset clears every entry.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     ra_addr / ra_data : operand A read port
//     rb_addr / rb_data : operand B read port
//     dbg_addr/dbg_data : debug read-back port
//     we, wa, wd        : write enable, write index, write data
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] ra_addr,
  output logic [DW-1:0]            ra_data,
  input  logic [$clog2(NREGS)-1:0] rb_addr,
  output logic [DW-1:0]            rb_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [DW-1:0]            wd
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Issue/writeback sequencer in front of a combinational ALU. Accepts one
//   instruction per four cycles over valid/ready, reads operands from the
//   register file (or an immediate for B), holds them on the ALU ports for
//   a settle cycle, captures the result and writes its low byte back.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     instr_valid/ready   : instruction handshake
//     instr_opcode/rd/ra/rb/imm_en/imm : instruction fields
//     A, B, Opcode        : registered ALU operands and opcode
//     ALU_Out, CarryOut   : ALU result inputs
//     res_valid           : one-cycle writeback pulse
//     res_data, res_carry : captured ALU result and carry
//     hi_reg              : upper byte of the last written-back result
//     dbg_addr, dbg_data  : combinational register-file read-back
module alu_issue_seq #(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4:0]      instr_opcode,
  input  logic [2:0]      instr_rd,
  input  logic [2:0]      instr_ra,
  input  logic [2:0]      instr_rb,
  input  logic            instr_imm_en,
  input  logic [DW-1:0]   instr_imm,
  output logic [DW-1:0]   A,
  output logic [DW-1:0]   B,
  output logic [4:0]      Opcode,
  input  logic [2*DW-1:0] ALU_Out,
  input  logic            CarryOut,
  output logic            res_valid,
  output logic [2*DW-1:0] res_data,
  output logic            res_carry,
  output logic [DW-1:0]   hi_reg,
  input  logic [2:0]      dbg_addr,
  output logic [DW-1:0]   dbg_data
);

  import alu_pkg::*;

  state_t        state;
  instr_t        instr_in;
  logic [2:0]    rd_p0;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          rf_we;

  always_comb begin
    instr_in        = '0;
    instr_in.opcode = instr_opcode;
    instr_in.rd     = instr_rd;
    instr_in.ra     = instr_ra;
    instr_in.rb     = instr_rb;
    instr_in.imm_en = instr_imm_en;
    instr_in.imm    = instr_imm;
  end

  assign instr_ready = (state == IDLE);
  assign res_valid   = (state == WB);
  // Writeback lands on the WB->IDLE edge, so an instruction accepted in the
  // following IDLE cycle already reads the new value.
  assign rf_we       = (state == WB);

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (instr_in.ra),
    .ra_data  (ra_data),
    .rb_addr  (instr_in.rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rd_p0),
    .wd       (res_data[DW-1:0])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      A         <= '0;
      B         <= '0;
      Opcode    <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      hi_reg    <= '0;
    end else begin
      case (state)
        // accept: latch destination and drive operands onto the ALU
        IDLE: begin
          if (instr_valid) begin
            rd_p0  <= instr_in.rd;
            A      <= ra_data;
            B      <= instr_in.imm_en ? instr_in.imm : rb_data;
            Opcode <= instr_in.opcode;
            state  <= ISSUE;
          end
        end
        // operands held stable while the ALU settles
        ISSUE: begin
          state <= CAPTURE;
        end
        // capture the ALU result
        CAPTURE: begin
          res_data  <= ALU_Out;
          res_carry <= CarryOut;
          state     <= WB;
        end
        // writeback: low byte to the register file, high byte to hi_reg
        WB: begin
          hi_reg <= res_data[2*DW-1:DW];
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  instr_opcode;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_ra;
  logic [2:0]  instr_rb;
  logic        instr_imm_en;
  logic [7:0]  instr_imm;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [4:0]  Opcode;
  logic [15:0] ALU_Out;
  logic        CarryOut;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_carry;
  logic [7:0]  hi_reg;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_ra     (instr_ra),
    .instr_rb     (instr_rb),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .A            (A),
    .B            (B),
    .Opcode       (Opcode),
    .ALU_Out      (ALU_Out),
    .CarryOut     (CarryOut),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .hi_reg       (hi_reg),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU: opcode 0 is a 16-bit add with carry at bit 8; any other
  // opcode concatenates the operands so the opcode pass-through is visible.
  logic [15:0] alu_sum;
  always_comb begin
    alu_sum = {8'h00, A} + {8'h00, B};
    if (Opcode == 5'd0) begin
      ALU_Out  = alu_sum;
      CarryOut = alu_sum[8];
    end else begin
      ALU_Out  = {A, B};
      CarryOut = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready && !rst) acc_q.push_back(cyc);
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        imm_en;
    logic [7:0]  imm;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [15:0] exp_res;
    logic        exp_c;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic imm_en, input logic [7:0] imm);
    instr_opcode = op;
    instr_rd     = rd;
    instr_ra     = ra;
    instr_rb     = rb;
    instr_imm_en = imm_en;
    instr_imm    = imm;
  endtask

  task automatic check_rf_all_zero(input string nm);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check(nm, {24'd0, dbg_data}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    drive(v.op, v.rd, v.ra, v.rb, v.imm_en, v.imm);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("issue_ready", {31'd0, instr_ready}, 32'd0);
    check("issue_A", {24'd0, A}, {24'd0, v.exp_a});
    check("issue_B", {24'd0, B}, {24'd0, v.exp_b});
    check("issue_opcode", {27'd0, Opcode}, {27'd0, v.op});
    check("issue_res_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("capture_ready", {31'd0, instr_ready}, 32'd0);
    check("capture_res_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("wb_res_valid", {31'd0, res_valid}, 32'd1);
    check("wb_ready", {31'd0, instr_ready}, 32'd0);
    check("wb_res_data", {16'd0, res_data}, {16'd0, v.exp_res});
    check("wb_res_carry", {31'd0, res_carry}, {31'd0, v.exp_c});
    @(posedge clk);
    #1;
    check("post_res_valid", {31'd0, res_valid}, 32'd0);
    check("post_ready", {31'd0, instr_ready}, 32'd1);
    check("post_hi_reg", {24'd0, hi_reg}, {24'd0, v.exp_res[15:8]});
    dbg_addr = v.rd;
    #1;
    check("post_rf_rd", {24'd0, dbg_data}, {24'd0, v.exp_res[7:0]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     rd    ra    rb    imm  imm    A      B      result    carry
    vecs[0] = '{5'd0,  3'd1, 3'd0, 3'd0, 1'b1, 8'hE7, 8'h00, 8'hE7, 16'h00E7, 1'b0};
    vecs[1] = '{5'd0,  3'd2, 3'd0, 3'd0, 1'b1, 8'h98, 8'h00, 8'h98, 16'h0098, 1'b0};
    vecs[2] = '{5'd0,  3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'hE7, 8'h98, 16'h017F, 1'b1};
    vecs[3] = '{5'd0,  3'd3, 3'd3, 3'd3, 1'b0, 8'h00, 8'h7F, 8'h7F, 16'h00FE, 1'b0};
    vecs[4] = '{5'd0,  3'd4, 3'd3, 3'd0, 1'b1, 8'h02, 8'hFE, 8'h02, 16'h0100, 1'b1};
    vecs[5] = '{5'h13, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00, 8'hE7, 8'h98, 16'hE798, 1'b0};

    rst = 1'b1;
    instr_valid = 1'b0;
    drive(5'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    dbg_addr = 3'd0;

    // reset
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_A", {24'd0, A}, 32'd0);
    check("rst_B", {24'd0, B}, 32'd0);
    check("rst_opcode", {27'd0, Opcode}, 32'd0);
    check("rst_hi_reg", {24'd0, hi_reg}, 32'd0);
    check_rf_all_zero("rst_rf");

    // table-driven instructions: immediate load, carry, aliasing, opcode pass-through
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end
    dbg_addr = 3'd3;
    #1;
    check("rf3_after_alias", {24'd0, dbg_data}, 32'h000000FE);

    // back-to-back with valid held: X then Y, fields changed while busy
    wait_ready();
    acc_q.delete();
    drive(5'd0, 3'd6, 3'd0, 3'd0, 1'b1, 8'h11);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(5'd0, 3'd5, 3'd0, 3'd0, 1'b1, 8'h5A);
    check("hs_busy_issue", {31'd0, instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("hs_busy_capture", {31'd0, instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("hs_busy_wb", {31'd0, instr_ready}, 32'd0);
    check("hs_x_res", {16'd0, res_data}, 32'h00000011);
    drive(5'd0, 3'd7, 3'd6, 3'd0, 1'b1, 8'h22);
    @(posedge clk);
    #1;
    check("hs_idle_ready", {31'd0, instr_ready}, 32'd1);
    dbg_addr = 3'd6;
    #1;
    check("hs_rf6", {24'd0, dbg_data}, 32'h00000011);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("hs_raw_A", {24'd0, A}, 32'h00000011);
    check("hs_y_B", {24'd0, B}, 32'h00000022);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hs_y_res_valid", {31'd0, res_valid}, 32'd1);
    check("hs_y_res", {16'd0, res_data}, 32'h00000033);
    @(posedge clk);
    #1;
    check("hs_accept_count", acc_q.size(), 32'd2);
    if (acc_q.size() == 2) check("hs_accept_gap", acc_q[1] - acc_q[0], 32'd4);
    dbg_addr = 3'd7;
    #1;
    check("hs_rf7", {24'd0, dbg_data}, 32'h00000033);
    dbg_addr = 3'd5;
    #1;
    check("hs_rf5_untouched", {24'd0, dbg_data}, 32'h00000098);

    // reset during CAPTURE
    wait_ready();
    drive(5'd0, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_A", {24'd0, A}, 32'd0);
    check("midrst_B", {24'd0, B}, 32'd0);
    check("midrst_res_data", {16'd0, res_data}, 32'd0);
    check("midrst_hi_reg", {24'd0, hi_reg}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_pulse", {31'd0, res_valid}, 32'd0);
      check("midrst_idle", {31'd0, instr_ready}, 32'd1);
    end
    check_rf_all_zero("midrst_rf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
Upstream issue/writeback sequencer for the combinational ALU (A[7:0], B[7:0], Opcode[4:0] -> ALU_Out[15:0], CarryOut).
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from an 8x8 register file or an immediate, drives the ALU, captures its result, and writes the result back.
- Gives the ALU a registered, clocked front end, so it can run programs instead of being driven directly by a bench.

Parameters:
NREGS, 8, register-file depth (power of two; index width RW = log2(NREGS) = 3)
DW, 8, operand width (must match the ALU A/B width)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept an instruction
instr_opcode  in  5  ALU opcode, passed through unchanged
instr_rd  in  3  destination register index
instr_ra  in  3  source register for A
instr_rb  in  3  source register for B
instr_imm_en  in  1  1 = B comes from instr_imm instead of RF[rb]
instr_imm  in  8  immediate operand
A  out  8  ALU operand A
B  out  8  ALU operand B
Opcode  out  5  ALU opcode
ALU_Out  in  16  ALU result
CarryOut  in  1  ALU carry
res_valid  out  1  one-cycle pulse: result written back
res_data  out  16  captured ALU_Out
res_carry  out  1  captured CarryOut
hi_reg  out  8  upper byte of the last result
dbg_addr  in  3  register-file read-back index
dbg_data  out  8  RF[dbg_addr], combinational read

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - All RF entries = 0.
  - A, B, Opcode, res_data, res_carry, hi_reg, res_valid = 0.
  - instr_ready = 1 in the cycle after rst deasserts.
- States: IDLE -> ISSUE -> CAPTURE -> WB -> IDLE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch the instruction fields.
  - Register A <= RF[ra].
  - Register B <= instr_imm_en ? instr_imm : RF[rb].
  - Register Opcode <= instr_opcode.
  - Go to ISSUE.
- ISSUE: instr_ready = 0. A/B/Opcode are stable for the whole cycle while the ALU settles. Go to CAPTURE.
- CAPTURE: res_data <= ALU_Out; res_carry <= CarryOut. Go to WB.
- WB:
  - RF[rd] <= res_data[7:0]; hi_reg <= res_data[15:8].
  - res_valid = 1 for exactly this cycle.
  - Go to IDLE.
- Throughput and latency:
  - Acceptance edge = cycle 0; res_valid is high in cycle 3.
  - Next accept is possible in cycle 4, so one instruction per 4 cycles.
- A, B and Opcode hold their last values in every state except the IDLE accept edge; there is no bubble-zeroing.
- Read-after-write: an instruction accepted in the cycle after WB sees the written value. WB completes before IDLE, so no forwarding is needed.
- Operand aliasing: ra == rb == rd is legal. Operands are read before the write.
- instr_valid while not ready is ignored. The offering side must hold its fields until accepted.
- rst in any state aborts the operation: no writeback and no res_valid pulse, and all state reinitialises.
- Only the low byte goes to the RF. The carry is reported only via res_carry and is not stored in the RF.

Decomposition:
- Shared package alu_pkg holds:
  - DW = 8, RW = 3, OPW = 5;
  - the state enum {IDLE, ISSUE, CAPTURE, WB};
  - the instruction struct {opcode, rd, ra, rb, imm_en, imm}.
- One natural sub-module: alu_regfile.
  - 8x8, two combinational read ports plus the dbg read port, one synchronous write port.
  - Reset clears all entries.
- The FSM, operand muxing and capture registers stay in alu_issue_seq.

Test Plan:
The bench instantiates alu_issue_seq and a behavioural ALU model (opcode 5'b00000 = 16-bit A+B, CarryOut = bit 8).
1. Reset: rst high for 2 cycles -> all dbg_data = 0, res_valid = 0, A = B = 0, instr_ready = 1 on the first cycle after release.
2. Immediate load:
   - opcode 0, ra = 0 (value 0), imm_en = 1, imm = 8'hE7, rd = 1 -> res_valid in cycle 3, res_data = 16'h00E7, RF[1] = 8'hE7.
   - Then imm = 8'h98 into rd = 2 -> RF[2] = 8'h98.
3. Carry path: opcode 0, ra = 1, rb = 2, rd = 3 -> A = 8'hE7, B = 8'h98 seen on the ALU ports during ISSUE; res_data = 16'h017F, res_carry = 1, RF[3] = 8'h7F, hi_reg = 8'h01.
4. Handshake: hold instr_valid high with back-to-back instructions -> acceptances exactly 4 cycles apart; instr_ready low in ISSUE, CAPTURE and WB; fields changed while not ready are ignored.
5. Aliasing: ra = rb = rd = 3 (8'h7F), opcode 0 -> res_data = 16'h00FE, RF[3] = 8'hFE.
6. Reset mid-op: assert rst during CAPTURE -> no res_valid, RF[rd] unchanged (all zero after reset), state IDLE, instr_ready = 1 the cycle after release.
